// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // MIPS images arrive most-significant byte first.
    localparam bit BIG_ENDIAN = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loaderState_e;

    // States in which the loader is consuming the byte stream.
    function automatic logic isActive(loaderState_e s);
        return s inside {LEN_HI, LEN_LO, DATA, CHK};
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer: shifts accepted bytes into a 32-bit word and
// pulses wordValid the cycle after the last byte of each word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byteEn,
    input  logic [BYTE_W-1:0] byteIn,
    output logic              wordValid,
    output logic [WORD_W-1:0] word,
    output logic              lastByte_c
);

    logic [BYTE_CNT_W-1:0] byteCnt;
    logic [WORD_W-1:0]     shiftReg;
    logic [WORD_W-1:0]     shiftNext;

    assign lastByte_c = (byteCnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_comb begin
        shiftNext = shiftReg;
        if (BIG_ENDIAN) begin
            shiftNext = {shiftReg[WORD_W-BYTE_W-1:0], byteIn};
        end else begin
            shiftNext = {byteIn, shiftReg[WORD_W-1:BYTE_W]};
        end
    end

    // Word register holds the completed word steady while the next one fills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteCnt   <= '0;
            shiftReg  <= '0;
            wordValid <= 1'b0;
            word      <= '0;
        end else begin
            wordValid <= byteEn && lastByte_c && !clear;
            if (clear) begin
                byteCnt  <= '0;
                shiftReg <= '0;
            end else if (byteEn) begin
                byteCnt  <= byteCnt + BYTE_CNT_W'(1);
                shiftReg <= shiftNext;
                if (lastByte_c) begin
                    word <= shiftNext;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory, holding the
// core in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAP_W = LEN_W + 1;
    localparam logic [CAP_W-1:0] CAPACITY = CAP_W'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loaderState_e TAIL_STATE = CHK;
`else
    localparam loaderState_e TAIL_STATE = DONE;
`endif

    loaderState_e state;
    loaderState_e stateNext;

    logic [7:0]       lenHiReg;
    logic [LEN_W-1:0] lenReg;
    logic [LEN_W-1:0] lenFull;
    logic             accept;
    logic             lastWord;
    logic             readyNext;
    logic             packerClear;
    logic             packerEn;
    logic             packerLast;
    logic             wordValid;
    logic             lenHiLoad;
    logic             lenLoad;
    logic             addrClear;
    logic             addrInc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xorReg;
`endif

    assign accept   = byte_valid && byte_ready;
    assign packerEn = accept && (state == DATA);
    assign lenFull  = LEN_W'({lenHiReg, byte_data});
    assign lastWord = (im_addr == ADDR_W'(lenReg - LEN_W'(1)));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packerClear),
        .byteEn     (packerEn),
        .byteIn     (byte_data),
        .wordValid  (wordValid),
        .word       (im_wdata),
        .lastByte_c (packerLast)
    );

    assign im_we = wordValid;

    // Next-state and datapath-control decode.
    always_comb begin
        stateNext   = state;
        packerClear = 1'b0;
        lenHiLoad   = 1'b0;
        lenLoad     = 1'b0;
        addrClear   = 1'b0;
        addrInc     = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    stateNext   = LEN_HI;
                    packerClear = 1'b1;
                    addrClear   = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    lenHiLoad = 1'b1;
                    stateNext = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    lenLoad = 1'b1;
                    if (lenFull == '0) begin
                        stateNext = TAIL_STATE;
                    end else if ({1'b0, lenFull} > CAPACITY) begin
                        stateNext = ERROR;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (wordValid) begin
                    if (lastWord) begin
                        stateNext = TAIL_STATE;
                    end else begin
                        addrInc = 1'b1;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    stateNext = (byte_data == xorReg) ? DONE : ERROR;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase

        // Stop taking bytes once the final data byte is in; nothing may follow it.
        readyNext = isActive(stateNext) && !(packerEn && packerLast && lastWord);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            core_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= stateNext;
            byte_ready <= readyNext;
            core_rst   <= (stateNext == DONE);
            busy       <= isActive(stateNext);
            done       <= (stateNext == DONE);
            error      <= (stateNext == ERROR);
        end
    end

    // Header capture and write-address counter; the address never advances
    // past the final word so it cannot wrap at full capacity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lenHiReg <= '0;
            lenReg   <= '0;
            im_addr  <= '0;
        end else begin
            if (lenHiLoad) begin
                lenHiReg <= byte_data;
            end
            if (lenLoad) begin
                lenReg <= lenFull;
            end
            if (addrClear) begin
                im_addr <= '0;
            end else if (addrInc) begin
                im_addr <= im_addr + ADDR_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and data bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xorReg <= '0;
        end else if (packerClear) begin
            xorReg <= '0;
        end else if (accept && (state inside {LEN_HI, LEN_LO, DATA})) begin
            xorReg <= xorReg ^ byte_data;
        end
    end
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the 5-stage pipeline's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS words.
- Writes each word into the instruction-memory write port and holds the pipeline core in reset until the image is complete.
- On success it releases the core so fetch starts at word address 0.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity is 2**ADDR_W words.
- LEN_W, 16, width of the word-count header field; must be ≥ ADDR_W+1.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  32  assembled instruction word.
- core_rst  out  1  active-low reset to the pipeline core; 0 holds the core.
- busy  out  1  load in progress.
- done  out  1  image loaded; sticky until the next start or reset.
- error  out  1  load aborted; sticky until the next start or reset.

Behaviour:
- Reset (rst=0, async): state=IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, core_rst=0, busy=0, done=0, error=0. A reset mid-load discards everything and returns to IDLE.
- A byte is accepted only on a cycle with byte_valid & byte_ready.
- Registered FSM: IDLE -> LEN_HI -> LEN_LO -> DATA -> [CHK] -> DONE; ERROR is reachable from LEN_LO and CHK.
- IDLE/DONE/ERROR:
  - byte_ready=0.
  - start moves to LEN_HI, clears done/error, zeros the word counter and im_addr, drives core_rst=0 and busy=1.
  - start in any other state is ignored.
- LEN_HI/LEN_LO:
  - Each accepts one byte, forming len[15:8], then len[7:0].
  - After LEN_LO, if len==0: go to DONE next cycle (or CHK when the feature is enabled).
  - If len > 2**ADDR_W: go to ERROR.
  - Otherwise: go to DATA.
- DATA:
  - byte_ready=1. Bytes shift into the word MSB-first (byte 0 lands in [31:24]).
  - The cycle after the 4th byte of a word is accepted: im_we=1 for exactly one cycle, with im_wdata=the word and im_addr=the current counter.
  - The address increments after the write. byte_ready stays 1 during the write cycle, so one byte per cycle is sustained.
  - When the write is word len-1, the next state is DONE (or CHK).
- DONE: done=1, busy=0, core_rst=1 registered, so the core leaves reset one cycle after the final im_we.
- ERROR: error=1, busy=0, core_rst stays 0.
- im_addr holds its last value when idle and never wraps, because len ≤ 2**ADDR_W.
- Gaps in byte_valid simply stall the FSM; there is no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running 8-bit XOR is taken over every accepted header and data byte.
  - State CHK accepts one trailing byte. If it equals the running XOR, go to DONE; otherwise go to ERROR with core_rst held at 0.
- Disabled: the CHK state, the XOR register and the trailing byte do not exist; the last data word goes straight to DONE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR} as a 3-bit localparam set;
  - the BYTES_PER_WORD=4 constant;
  - the byte-order convention constant (big-endian).
- One sub-module is natural: imem_word_packer (byte shift register plus 2-bit byte counter that emits word_valid/word).
- FSM, address counter and core_rst generation stay in imem_loader.

Test Plan:
1. Reset then start; stream 00 02 | 20 08 00 05 | 00 00 00 08 -> im_we pulses at addr 0 with 32'h20080005 and at addr 1 with 32'h00000008. core_rst rises the cycle after the second im_we; done=1.
2. Header 00 00 -> no im_we; done=1 and core_rst=1 within 2 cycles after the LEN_LO byte.
3. With ADDR_W=4, header 00 11 (17 words) -> error=1, core_rst=0, byte_ready=0, no writes.
4. Inject random byte_valid gaps and pulse start during DATA -> start is ignored; words and addresses identical to scenario 1.
5. Deassert rst after the 5th byte of a 2-word load -> all outputs return to their reset values immediately. A fresh start plus full stream then loads correctly from addr 0.
6. With IMEM_LOADER_CHECKSUM_EN: stream of scenario 1 plus checksum 8'h27 (XOR of all 10 bytes) -> done=1. The same stream with trailing 8'h00 -> error=1, core_rst=0.
